// File: rtl/dual_port_memory_arbiter_if.sv
// Requester-side bus of the dual-port memory arbiter: one request channel
// (read or write) plus a read-response channel with no backpressure.
interface dual_port_memory_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_wmask;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dual_port_memory_arbiter.sv
// Round-robin arbiter sharing a dual-port memory between two requesters:
// writes go out on port A, reads on port B, read responses are steered back by tag.
module dual_port_memory_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_port_memory_arbiter_if.slave m0,
    dual_port_memory_arbiter_if.slave m1,
    output logic [DATA_W/8-1:0]   mem_write_mask,
    output logic [ADDR_W-1:0]     mem_addr_a,
    output logic [ADDR_W-1:0]     mem_addr_b,
    output logic [DATA_W-1:0]     mem_write_data,
    input  logic [DATA_W-1:0]     mem_read_data
);
    localparam int MASK_W = DATA_W / 8;

    logic                    last_grant_reg;
    logic [ADDR_W-1:0]       wr_addr_reg;
    logic [DATA_W-1:0]       wr_data_reg;
    logic [ADDR_W-1:0]       rd_addr_reg;
    logic [READ_LATENCY-1:0] tag_valid_reg;
    logic [READ_LATENCY-1:0] tag_id_reg;

    logic                    grant0;
    logic                    grant1;
    logic                    any_grant;
    logic                    sel_we;
    logic [MASK_W-1:0]       sel_wmask;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    wr_grant;
    logic                    rd_grant;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        grant0    = rst_n && m0.req_valid && (!m1.req_valid || last_grant_reg);
        grant1    = rst_n && m1.req_valid && (!m0.req_valid || !last_grant_reg);
        any_grant = grant0 || grant1;
        sel_we    = grant1 ? m1.req_we    : m0.req_we;
        sel_wmask = grant1 ? m1.req_wmask : m0.req_wmask;
        sel_addr  = grant1 ? m1.req_addr  : m0.req_addr;
        sel_wdata = grant1 ? m1.req_wdata : m0.req_wdata;
        wr_grant  = any_grant && sel_we;
        rd_grant  = any_grant && !sel_we;
    end

    assign m0.req_ready = grant0;
    assign m1.req_ready = grant1;

    assign mem_write_mask = wr_grant ? sel_wmask : '0;
    assign mem_addr_a     = wr_grant ? sel_addr  : wr_addr_reg;
    assign mem_write_data = wr_grant ? sel_wdata : wr_data_reg;
    assign mem_addr_b     = rd_grant ? sel_addr  : rd_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            rd_addr_reg    <= '0;
        end else begin
            if (any_grant) begin
                last_grant_reg <= grant1;
            end
            if (wr_grant) begin
                wr_addr_reg <= sel_addr;
                wr_data_reg <= sel_wdata;
            end
            if (rd_grant) begin
                rd_addr_reg <= sel_addr;
            end
        end
    end

    // Tag pipe tracks the memory read latency; the exiting stage steers rsp_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg[0] <= rd_grant;
            tag_id_reg[0]    <= grant1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end
        end
    end

    assign m0.rsp_valid = tag_valid_reg[READ_LATENCY-1] && !tag_id_reg[READ_LATENCY-1];
    assign m1.rsp_valid = tag_valid_reg[READ_LATENCY-1] &&  tag_id_reg[READ_LATENCY-1];
    assign m0.rsp_rdata = mem_read_data;
    assign m1.rsp_rdata = mem_read_data;

endmodule
